// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of a 16-bit saturating add/sub unit with a registered response slot.
// Optional grant counters (gnt_cnt0/gnt_cnt1, clr_stats) are enabled by defining ADDSUB_ARB_STATS_EN.
module addsub_arbiter #(
  parameter int unsigned PRIO_INIT = 0,
  parameter int unsigned DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_sub,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              rsp_n,
  output logic              rsp_z,
  output logic              rsp_v
`ifdef ADDSUB_ARB_STATS_EN
  ,
  input  logic              clr_stats,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1
`endif
);

  localparam int unsigned W  = DATA_W;
  localparam int unsigned XW = W + 1;

  generate
    if (DATA_W != 16) begin : g_bad_width
      $error("addsub_arbiter: DATA_W must be 16");
    end
  endgenerate

  logic          prio;
  logic          can_accept;
  logic          any_valid;
  logic          gnt_id;
  logic          accept;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_sub;
  logic [XW-1:0] true_res;
  logic          ovf;
  logic [W-1:0]  sat_sum;

  // Grant selection and the shared datapath, evaluated on the granted operands.
  always_comb begin
    can_accept = ~rsp_valid | rsp_ready;
    any_valid  = req0_valid | req1_valid;
    gnt_id     = (req0_valid & req1_valid) ? prio : req1_valid;
    accept     = can_accept & any_valid;
    req0_ready = accept & ~gnt_id;
    req1_ready = accept & gnt_id;
    op_a       = gnt_id ? req1_a   : req0_a;
    op_b       = gnt_id ? req1_b   : req0_b;
    op_sub     = gnt_id ? req1_sub : req0_sub;
    if (op_sub) begin
      true_res = {op_a[W-1], op_a} - {op_b[W-1], op_b};
    end else begin
      true_res = {op_a[W-1], op_a} + {op_b[W-1], op_b};
    end
    // The sign-extended result overflowed 16 bits when its top two bits disagree.
    ovf = true_res[XW-1] ^ true_res[W-1];
    if (!ovf) begin
      sat_sum = true_res[W-1:0];
    end else if (true_res[XW-1]) begin
      sat_sum = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat_sum = {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= 1'(PRIO_INIT);
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_n     <= 1'b0;
      rsp_z     <= 1'b0;
      rsp_v     <= 1'b0;
    end else if (accept) begin
      prio      <= ~gnt_id;
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_id;
      rsp_sum   <= sat_sum;
      rsp_n     <= sat_sum[W-1];
      rsp_z     <= (sat_sum == '0);
      rsp_v     <= ovf;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ADDSUB_ARB_STATS_EN
  // Saturating per-requester accept counters; a clear wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req0_ready && (gnt_cnt0 != 16'hFFFF)) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (req1_ready && (gnt_cnt1 != 16'hFFFF)) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule
